pack_ins: RTL and testbench

Elastic dataflow stage that packs consecutive narrow tokens into one wide token. It sits directly upstream of the zero-extension operator and feeds the same wide-datapath consumers. A short final group flagged with `ins_last` is emitted zero-padded in its upper lanes, so a single-token group yields exactly the zero-extended value. Handshake is valid/ready with the same semantics as every other dataflow unit.

---
 rtl/pack_ins.sv | 62 ++++++
 tb/tb_pack_ins.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/pack_ins.sv
// Packs consecutive narrow tokens into one wide word, little-endian lanes.
// A group closed early by ins_last is emitted with its upper lanes zero.
module pack_ins #(
  parameter int INPUT_WIDTH  = 8,
  parameter int OUTPUT_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [INPUT_WIDTH-1:0]  ins,
  input  logic                    ins_last,
  input  logic                    ins_valid,
  output logic                    ins_ready,
  output logic [OUTPUT_WIDTH-1:0] outs,
  output logic                    outs_valid,
  input  logic                    outs_ready
);

  localparam int N  = OUTPUT_WIDTH / INPUT_WIDTH;
  localparam int CW = $clog2(N);
  localparam int AW = (N - 1) * INPUT_WIDTH;

  logic [CW-1:0]           r_cnt;
  logic [AW-1:0]           r_acc;
  logic [OUTPUT_WIDTH-1:0] r_outs;
  logic                    r_outs_valid;

  logic                    w_accept;
  logic                    w_complete;
  logic [OUTPUT_WIDTH-1:0] w_word;

  assign ins_ready  = !r_outs_valid | outs_ready;
  assign w_accept   = ins_valid & ins_ready;
  assign w_complete = w_accept & ((r_cnt == CW'(N - 1)) | ins_last);

  // Lanes at and above r_cnt in r_acc are always zero, so OR-ing the new lane in is exact.
  assign w_word = {{INPUT_WIDTH{1'b0}}, r_acc}
                | (OUTPUT_WIDTH'(ins) << (int'(r_cnt) * INPUT_WIDTH));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt        <= '0;
      r_acc        <= '0;
      r_outs       <= '0;
      r_outs_valid <= 1'b0;
    end else if (w_complete) begin
      r_outs       <= w_word;
      r_outs_valid <= 1'b1;
      r_cnt        <= '0;
      r_acc        <= '0;
    end else begin
      if (w_accept) begin
        r_acc <= r_acc | (AW'(ins) << (int'(r_cnt) * INPUT_WIDTH));
        r_cnt <= r_cnt + 1'b1;
      end
      if (r_outs_valid && outs_ready) r_outs_valid <= 1'b0;
    end
  end

  assign outs       = r_outs;
  assign outs_valid = r_outs_valid;

endmodule

// File: tb/tb_pack_ins.sv
// Bench for pack_ins: directed groups, stall, reset and random traffic against a lane-queue model.
// Handshake: a transfer occurs on a rising edge where valid and ready are both high.
module tb_pack_ins;

  localparam int IW = 8;
  localparam int OW = 32;
  localparam int N  = OW / IW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [IW-1:0] ins = '0;
  logic          ins_last = 1'b0;
  logic          ins_valid = 1'b0;
  logic          ins_ready;
  logic [OW-1:0] outs;
  logic          outs_valid;
  logic          outs_ready = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [OW-1:0] exp_q[$];
  logic [IW-1:0] grp_q[$];
  logic          m_valid = 1'b0;

  pack_ins #(.INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW)) dut (
    .clk(clk), .rst(rst), .ins(ins), .ins_last(ins_last), .ins_valid(ins_valid),
    .ins_ready(ins_ready), .outs(outs), .outs_valid(outs_valid), .outs_ready(outs_ready)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: lanes queued per group, word formed by arithmetic
  always @(negedge clk) begin
    logic          rdy;
    logic          nxt;
    logic [OW-1:0] w;
    if (!rst) begin
      grp_q.delete();
      exp_q.delete();
      m_valid = 1'b0;
    end else begin
      rdy = !m_valid || outs_ready;
      chk("ins_ready", OW'(ins_ready), OW'(rdy));
      chk("outs_valid", OW'(outs_valid), OW'(m_valid));
      nxt = m_valid && !outs_ready;
      if (ins_valid && rdy) begin
        grp_q.push_back(ins);
        if (ins_last || grp_q.size() == N) begin
          w = '0;
          foreach (grp_q[i]) w = w + (OW'(grp_q[i]) << (IW * i));
          exp_q.push_back(w);
          grp_q.delete();
          nxt = 1'b1;
        end
      end
      m_valid = nxt;
    end
  end

  // monitor: pop on every output transfer, and hold-check stalled words
  logic          prev_stall = 1'b0;
  logic [OW-1:0] prev_outs  = '0;
  always @(negedge clk) begin
    logic [OW-1:0] e;
    if (rst) begin
      if (prev_stall) chk("stall_hold", outs, prev_outs);
      if (outs_valid && outs_ready) begin
        if (exp_q.size() == 0) chk("unexpected_word", outs, 'x);
        else begin
          e = exp_q.pop_front();
          chk("word", outs, e);
        end
      end
      prev_stall = outs_valid && !outs_ready;
      prev_outs  = outs;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // driver tasks
  task automatic send(input logic [IW-1:0] d, input logic l);
    bit done = 0;
    ins = d; ins_last = l; ins_valid = 1'b1;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      if (ins_ready) done = 1;
    end
    if (!done) chk("send_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic idle();
    ins_valid = 1'b0; ins_last = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("rst_outs_valid", OW'(outs_valid), 0);
    chk("rst_ins_ready", OW'(ins_ready), 1);
    chk("rst_outs", outs, 0);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  initial begin
    do_reset();
    // full group, back-to-back
    outs_ready = 1'b1;
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
    idle();
    @(negedge clk); chk("word_44332211", outs, 32'h44332211);
    @(posedge clk); #1;
    // short groups and restart at lane 0
    send(8'hAB, 1); idle();
    @(negedge clk); chk("word_000000ab", outs, 32'h000000AB);
    @(posedge clk); #1;
    send(8'h01, 0); send(8'h02, 0); send(8'h03, 1); idle();
    @(negedge clk); chk("word_00030201", outs, 32'h00030201);
    @(posedge clk); #1;
    send(8'h05, 0); send(8'h06, 0); send(8'h07, 0); send(8'h08, 0); idle();
    @(negedge clk); chk("word_08070605", outs, 32'h08070605);
    @(posedge clk); #1;
    // stall with a pending word
    outs_ready = 1'b0;
    send(8'hEF, 0); send(8'hBE, 0); send(8'hAD, 0); send(8'hDE, 0);
    ins = 8'h99; ins_last = 1'b1; ins_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("stall_outs", outs, 32'hDEADBEEF);
      chk("stall_valid", OW'(outs_valid), 1);
      chk("stall_ready", OW'(ins_ready), 0);
    end
    @(posedge clk); #1;
    outs_ready = 1'b1;
    send(8'h99, 1); idle();
    @(negedge clk); chk("word_00000099", outs, 32'h00000099);
    @(posedge clk); #1;
    // streaming two groups with drain/complete overlap
    for (int i = 1; i <= 8; i++) send(IW'(i), 0);
    idle();
    repeat (2) @(posedge clk); #1;
    // reset mid-group
    send(8'hAA, 0); send(8'hBB, 0); idle();
    do_reset();
    send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0); idle();
    @(negedge clk); chk("word_after_reset", outs, 32'h04030201);
    @(posedge clk); #1;
    // reset with a pending word
    outs_ready = 1'b0;
    send(8'h10, 0); send(8'h20, 0); send(8'h30, 1); idle();
    @(negedge clk); chk("pending_valid", OW'(outs_valid), 1);
    do_reset();
    outs_ready = 1'b1;
    // random traffic
    for (int c = 0; c < 10000; c++) begin
      ins_valid  = ($urandom_range(0, 3) != 0);
      ins        = IW'($urandom);
      ins_last   = ($urandom_range(0, 5) == 0);
      outs_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    idle();
    outs_ready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("exp_q_empty", OW'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
